// File: rtl/sprite_line_blitter.sv
// Per-scanline sprite renderer: clears one frame-buffer line, then paints enabled sprites in index order.
// State | meaning: IDLE wait | CLEAR background fill | SCAN test one object | DRAW fetch row | DRAIN retire last pixel | FINISH done pulse
module sprite_line_blitter #(
    parameter int          NUM_OBJ      = 4,
    parameter int          SCREEN_W     = 640,
    parameter logic [3:0]  BG_INDEX     = 4'h0,
    parameter logic [3:0]  TRANSP_INDEX = 4'hF
) (
    input  logic                    Clk50,
    input  logic                    Reset,
    input  logic                    line_start,
    input  logic [9:0]              line_y,
    input  logic [NUM_OBJ-1:0]      obj_en,
    input  logic [10*NUM_OBJ-1:0]   obj_x,
    input  logic [10*NUM_OBJ-1:0]   obj_y,
    input  logic [10*NUM_OBJ-1:0]   obj_w,
    input  logic [10*NUM_OBJ-1:0]   obj_h,
    input  logic [18*NUM_OBJ-1:0]   obj_base,
    output logic [17:0]             rom_addr,
    input  logic [3:0]              rom_data,
    output logic                    wr_en,
    output logic [9:0]              wr_x,
    output logic [9:0]              wr_y,
    output logic [3:0]              wr_data,
    output logic                    busy,
    output logic                    done,
    output logic                    overrun
);

    localparam int OW = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
    localparam logic [OW-1:0] LAST_OBJ = OW'(NUM_OBJ - 1);
    localparam logic [9:0]    LAST_X   = 10'(SCREEN_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SCAN,
        S_DRAW,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t          state_q, state_d;
    logic [9:0]      clear_x_q, clear_x_d;
    logic [OW-1:0]   obj_q, obj_d;
    logic [9:0]      col_q, col_d;
    logic [17:0]     row_base_q, row_base_d;
    logic [9:0]      ox_q, ox_d;
    logic [9:0]      w_q, w_d;
    logic            pv_q, pv_d;
    logic [10:0]     px_q, px_d;
    logic [9:0]      wr_y_q, wr_y_d;
    logic            overrun_q, overrun_d;

    logic [9:0]      sel_x, sel_y, sel_w, sel_h, dy;
    logic [17:0]     sel_base, row_off;
    logic [10:0]     y_end;
    logic            hit;

    always_comb begin
        sel_x    = obj_x[10*obj_q +: 10];
        sel_y    = obj_y[10*obj_q +: 10];
        sel_w    = obj_w[10*obj_q +: 10];
        sel_h    = obj_h[10*obj_q +: 10];
        sel_base = obj_base[18*obj_q +: 18];
        y_end    = {1'b0, sel_y} + {1'b0, sel_h};
        dy       = wr_y_q - sel_y;
        row_off  = 18'(dy) * 18'(sel_w);
        hit      = obj_en[obj_q] && (sel_w != 10'd0) && (sel_h != 10'd0)
                   && (sel_y <= wr_y_q) && ({1'b0, wr_y_q} < y_end);
    end

    always_ff @(posedge Clk50) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            clear_x_q  <= '0;
            obj_q      <= '0;
            col_q      <= '0;
            row_base_q <= '0;
            ox_q       <= '0;
            w_q        <= '0;
            pv_q       <= 1'b0;
            px_q       <= '0;
            wr_y_q     <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            clear_x_q  <= clear_x_d;
            obj_q      <= obj_d;
            col_q      <= col_d;
            row_base_q <= row_base_d;
            ox_q       <= ox_d;
            w_q        <= w_d;
            pv_q       <= pv_d;
            px_q       <= px_d;
            wr_y_q     <= wr_y_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clear_x_d  = clear_x_q;
        obj_d      = obj_q;
        col_d      = col_q;
        row_base_d = row_base_q;
        ox_d       = ox_q;
        w_d        = w_q;
        pv_d       = 1'b0;
        px_d       = px_q;
        wr_y_d     = wr_y_q;
        overrun_d  = overrun_q;
        rom_addr   = '0;
        wr_en      = 1'b0;
        wr_x       = '0;
        wr_data    = '0;
        done       = 1'b0;
        busy       = (state_q == S_CLEAR) || (state_q == S_SCAN)
                     || (state_q == S_DRAW) || (state_q == S_DRAIN);

        if (line_start && busy) overrun_d = 1'b1;

        // Retire the pixel fetched last cycle; off-screen columns are dropped, not wrapped.
        if (pv_q && (rom_data != TRANSP_INDEX) && (px_q < 11'(SCREEN_W))) begin
            wr_en   = 1'b1;
            wr_x    = px_q[9:0];
            wr_data = rom_data;
        end

        case (state_q)
            S_IDLE: begin
                if (line_start) begin
                    wr_y_d    = line_y;
                    clear_x_d = '0;
                    state_d   = S_CLEAR;
                end
            end
            S_CLEAR: begin
                wr_en   = 1'b1;
                wr_x    = clear_x_q;
                wr_data = BG_INDEX;
                if (clear_x_q == LAST_X) begin
                    obj_d   = '0;
                    state_d = S_SCAN;
                end else begin
                    clear_x_d = clear_x_q + 10'd1;
                end
            end
            S_SCAN: begin
                ox_d  = sel_x;
                w_d   = sel_w;
                col_d = '0;
                if (hit) begin
                    row_base_d = sel_base + row_off;
                    state_d    = S_DRAW;
                end else if (obj_q == LAST_OBJ) begin
                    state_d = S_FINISH;
                end else begin
                    obj_d = obj_q + OW'(1);
                end
            end
            S_DRAW: begin
                rom_addr = row_base_q + 18'(col_q);
                pv_d     = 1'b1;
                px_d     = {1'b0, ox_q} + {1'b0, col_q};
                if (col_q == w_q - 10'd1) state_d = S_DRAIN;
                else                      col_d   = col_q + 10'd1;
            end
            S_DRAIN: begin
                if (obj_q == LAST_OBJ) begin
                    state_d = S_FINISH;
                end else begin
                    obj_d   = obj_q + OW'(1);
                    state_d = S_SCAN;
                end
            end
            S_FINISH: begin
                done = 1'b1;
                if (line_start) begin
                    wr_y_d    = line_y;
                    clear_x_d = '0;
                    state_d   = S_CLEAR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign wr_y    = wr_y_q;
    assign overrun = overrun_q;

endmodule
